// File: rtl/nios_sys_pio_irq_servicer.sv
// Hardware servicer for an edge-capturing button PIO: programs the irq mask, then on each irq reads,
// clears and level-samples the PIO and emits one event word. Optional hold-off: PIO_SVC_HOLDOFF_EN.
module nios_sys_pio_irq_servicer #(
  parameter int              N_IN           = 2,
  parameter logic [N_IN-1:0] MASK_INIT      = 2'b11,
  parameter int              READ_LATENCY   = 1,
  parameter int              HOLDOFF_CYCLES = 50000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            irq,
  output logic [1:0]      avm_address,
  output logic            avm_read,
  output logic            avm_write,
  output logic [31:0]     avm_writedata,
  input  logic [31:0]     avm_readdata,
  input  logic            avm_waitrequest,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [N_IN-1:0] evt_edges,
  output logic [N_IN-1:0] evt_level,
  output logic [15:0]     evt_count,
  output logic            busy
);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_RD_EDGE, S_WAIT_EDGE, S_CLR, S_RD_LVL, S_WAIT_LVL, S_EMIT
`ifdef PIO_SVC_HOLDOFF_EN
    , S_HOLD, S_HOLD_CLR
`endif
  } state_t;

  localparam logic [2:0] RL_LAST = 3'(READ_LATENCY - 1);

  state_t            state, state_d;
  logic [1:0]        addr_d;
  logic              rd_d, wr_d, valid_d, accepted;
  logic [31:0]       wdata_d;
  logic [N_IN-1:0]   edges_d, level_d;
  logic [15:0]       count_d;
  logic [2:0]        wait_cnt, wait_d;
  logic              unused_readdata;
`ifdef PIO_SVC_HOLDOFF_EN
  logic [31:0]       hold_cnt, hold_d;
`endif

  assign unused_readdata = ^avm_readdata;
  assign accepted        = (avm_read || avm_write) && !avm_waitrequest;
  assign busy            = (state != S_IDLE);

  // Bus and event outputs are registered and decoded from the next state, so a request
  // stays asserted with stable address/data for as long as the state waits on acceptance.
  always_comb begin
    state_d = state;
    addr_d  = avm_address;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    wdata_d = avm_writedata;
    valid_d = 1'b0;
    edges_d = evt_edges;
    level_d = evt_level;
    count_d = evt_count;
    wait_d  = wait_cnt;
`ifdef PIO_SVC_HOLDOFF_EN
    hold_d  = hold_cnt;
`endif
    case (state)
      S_INIT:      if (accepted) state_d = S_IDLE;
      S_IDLE:      if (irq) state_d = S_RD_EDGE;
      S_RD_EDGE: begin
        if (accepted) begin
          state_d = S_WAIT_EDGE;
          wait_d  = '0;
        end
      end
      S_WAIT_EDGE: begin
        if (wait_cnt == RL_LAST) begin
          edges_d = avm_readdata[N_IN-1:0];
          state_d = S_CLR;
        end else begin
          wait_d = wait_cnt + 3'd1;
        end
      end
      S_CLR:       if (accepted) state_d = S_RD_LVL;
      S_RD_LVL: begin
        if (accepted) begin
          state_d = S_WAIT_LVL;
          wait_d  = '0;
        end
      end
      S_WAIT_LVL: begin
        if (wait_cnt == RL_LAST) begin
          level_d = avm_readdata[N_IN-1:0];
          state_d = (evt_edges == '0) ? S_IDLE : S_EMIT;
        end else begin
          wait_d = wait_cnt + 3'd1;
        end
      end
      S_EMIT: begin
        if (evt_valid && evt_ready) begin
          count_d = evt_count + 16'd1;
`ifdef PIO_SVC_HOLDOFF_EN
          state_d = S_HOLD;
          hold_d  = '0;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef PIO_SVC_HOLDOFF_EN
      S_HOLD: begin
        if (hold_cnt == 32'(HOLDOFF_CYCLES - 1)) state_d = S_HOLD_CLR;
        else hold_d = hold_cnt + 32'd1;
      end
      S_HOLD_CLR:  if (accepted) state_d = S_IDLE;
`endif
      default:     state_d = S_INIT;
    endcase

    case (state_d)
      S_INIT: begin
        wr_d    = 1'b1;
        addr_d  = 2'd2;
        wdata_d = 32'(MASK_INIT);
      end
      S_RD_EDGE: begin
        rd_d   = 1'b1;
        addr_d = 2'd3;
      end
      S_CLR: begin
        wr_d    = 1'b1;
        addr_d  = 2'd3;
        wdata_d = 32'(edges_d);
      end
      S_RD_LVL: begin
        rd_d   = 1'b1;
        addr_d = 2'd0;
      end
      S_EMIT:      valid_d = 1'b1;
`ifdef PIO_SVC_HOLDOFF_EN
      // Any write clears the capture register; this discards bounce edges from the hold-off.
      S_HOLD_CLR: begin
        wr_d    = 1'b1;
        addr_d  = 2'd3;
        wdata_d = 32'({N_IN{1'b1}});
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_INIT;
      avm_address   <= '0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= '0;
      evt_valid     <= 1'b0;
      evt_edges     <= '0;
      evt_level     <= '0;
      evt_count     <= '0;
      wait_cnt      <= '0;
`ifdef PIO_SVC_HOLDOFF_EN
      hold_cnt      <= '0;
`endif
    end else begin
      state         <= state_d;
      avm_address   <= addr_d;
      avm_read      <= rd_d;
      avm_write     <= wr_d;
      avm_writedata <= wdata_d;
      evt_valid     <= valid_d;
      evt_edges     <= edges_d;
      evt_level     <= level_d;
      evt_count     <= count_d;
      wait_cnt      <= wait_d;
`ifdef PIO_SVC_HOLDOFF_EN
      hold_cnt      <= hold_d;
`endif
    end
  end

endmodule
